// File: rtl/messbauer_velocity_waveform_generator.sv
// Mossbauer drive velocity reference generator.
// Produces a saw-tooth or triangle waveform with programmable amplitude and
// saw-tooth fall step, plus a period-start pulse, a per-period channel index
// and a wrapping period counter. One waveform step per rising edge of `channel`.
// Optional peak dwell: define MESSBAUER_WAVEFORM_PEAK_HOLD_EN to add the
// `peak_hold` input and the HOLD state (the peak is held for peak_hold cycles).
module messbauer_velocity_waveform_generator #(
    parameter int DATA_WIDTH       = 12,
    parameter int INDEX_WIDTH      = 14,
    parameter int PERIOD_CNT_WIDTH = 16
) (
    input  logic                        channel,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        mode,
    input  logic [DATA_WIDTH-1:0]       amplitude,
    input  logic [DATA_WIDTH-1:0]       reverse_step,
`ifdef MESSBAUER_WAVEFORM_PEAK_HOLD_EN
    input  logic [DATA_WIDTH-1:0]       peak_hold,
`endif
    output logic [DATA_WIDTH-1:0]       out_value,
    output logic                        direction,
    output logic                        period_start,
    output logic [INDEX_WIDTH-1:0]      channel_index,
    output logic [PERIOD_CNT_WIDTH-1:0] period_count,
    output logic                        busy
);

    localparam logic [DATA_WIDTH-1:0]       ZERO_DW = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0]       ONE_DW  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [INDEX_WIDTH-1:0]      CI_ZERO = {INDEX_WIDTH{1'b0}};
    localparam logic [INDEX_WIDTH-1:0]      CI_ONE  = {{(INDEX_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [INDEX_WIDTH-1:0]      CI_MAX  = {INDEX_WIDTH{1'b1}};
    localparam logic [PERIOD_CNT_WIDTH-1:0] PC_ZERO = {PERIOD_CNT_WIDTH{1'b0}};
    localparam logic [PERIOD_CNT_WIDTH-1:0] PC_ONE  = {{(PERIOD_CNT_WIDTH-1){1'b0}}, 1'b1};

`ifdef MESSBAUER_WAVEFORM_PEAK_HOLD_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RISE = 2'd1,
        ST_FALL = 2'd2,
        ST_HOLD = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RISE = 2'd1,
        ST_FALL = 2'd2
    } state_t;
`endif

    // Saturating subtraction: the waveform never wraps below zero.
    function automatic logic [DATA_WIDTH-1:0] sat_sub(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH-1:0] r;
        if (a > b) begin
            r = a - b;
        end else begin
            r = ZERO_DW;
        end
        return r;
    endfunction

    // Fall step: triangle always falls by one; saw-tooth uses reverse_step with 0 read as 1.
    function automatic logic [DATA_WIDTH-1:0] eff_step(
        input logic                  tri_mode,
        input logic [DATA_WIDTH-1:0] rstep
    );
        logic [DATA_WIDTH-1:0] r;
        if (tri_mode) begin
            r = ONE_DW;
        end else if (rstep == ZERO_DW) begin
            r = ONE_DW;
        end else begin
            r = rstep;
        end
        return r;
    endfunction

    state_t                        state_q;
    logic [DATA_WIDTH-1:0]         out_q;
    logic                          dir_q;
    logic                          ps_q;
    logic [INDEX_WIDTH-1:0]        ci_q;
    logic [PERIOD_CNT_WIDTH-1:0]   pc_q;
    logic                          busy_q;
    logic [DATA_WIDTH-1:0]         amp_q;
    logic [DATA_WIDTH-1:0]         step_q;
`ifdef MESSBAUER_WAVEFORM_PEAK_HOLD_EN
    logic [DATA_WIDTH-1:0]         hold_l_q;
    logic [DATA_WIDTH-1:0]         hold_cnt_q;
`endif

    logic [DATA_WIDTH-1:0]         fall_next_d;
    logic [DATA_WIDTH-1:0]         peak_next_d;
    logic [DATA_WIDTH-1:0]         step_new_d;
    logic [INDEX_WIDTH-1:0]        ci_inc_d;
    logic                          start_d;

    assign fall_next_d = sat_sub(out_q, step_q);
    assign peak_next_d = sat_sub(amp_q, step_q);
    assign step_new_d  = eff_step(mode, reverse_step);

    // Next channel index and period-start decision (IDLE exit or zero crossing with enable).
    always_comb begin
        ci_inc_d = ci_q;
        start_d  = 1'b0;
        if (ci_q == CI_MAX) begin
            ci_inc_d = ci_q;
        end else begin
            ci_inc_d = ci_q + CI_ONE;
        end
        case (state_q)
            ST_IDLE: start_d = enable;
            ST_FALL: start_d = enable && (fall_next_d == ZERO_DW);
            default: start_d = 1'b0;
        endcase
    end

    // Waveform state machine with all outputs registered.
    always_ff @(posedge channel) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            out_q      <= ZERO_DW;
            dir_q      <= 1'b0;
            ps_q       <= 1'b0;
            ci_q       <= CI_ZERO;
            pc_q       <= PC_ZERO;
            busy_q     <= 1'b0;
            amp_q      <= ZERO_DW;
            step_q     <= ZERO_DW;
`ifdef MESSBAUER_WAVEFORM_PEAK_HOLD_EN
            hold_l_q   <= ZERO_DW;
            hold_cnt_q <= ZERO_DW;
`endif
        end else if (start_d) begin
            // New period: configuration is only sampled here.
            state_q    <= ST_RISE;
            out_q      <= ZERO_DW;
            dir_q      <= 1'b0;
            ps_q       <= 1'b1;
            ci_q       <= CI_ZERO;
            pc_q       <= pc_q + PC_ONE;
            busy_q     <= 1'b1;
            amp_q      <= amplitude;
            step_q     <= step_new_d;
`ifdef MESSBAUER_WAVEFORM_PEAK_HOLD_EN
            hold_l_q   <= peak_hold;
`endif
        end else begin
            ps_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_IDLE;
                end
                ST_RISE: begin
                    ci_q <= ci_inc_d;
                    if (out_q < amp_q) begin
                        out_q <= out_q + ONE_DW;
                    end else begin
`ifdef MESSBAUER_WAVEFORM_PEAK_HOLD_EN
                        if (hold_l_q != ZERO_DW) begin
                            state_q    <= ST_HOLD;
                            out_q      <= amp_q;
                            dir_q      <= 1'b0;
                            hold_cnt_q <= hold_l_q - ONE_DW;
                        end else begin
                            state_q <= ST_FALL;
                            dir_q   <= 1'b1;
                            out_q   <= peak_next_d;
                        end
`else
                        state_q <= ST_FALL;
                        dir_q   <= 1'b1;
                        out_q   <= peak_next_d;
`endif
                    end
                end
`ifdef MESSBAUER_WAVEFORM_PEAK_HOLD_EN
                ST_HOLD: begin
                    ci_q <= ci_inc_d;
                    if (hold_cnt_q == ZERO_DW) begin
                        state_q <= ST_FALL;
                        dir_q   <= 1'b1;
                        out_q   <= peak_next_d;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - ONE_DW;
                    end
                end
`endif
                ST_FALL: begin
                    if (fall_next_d != ZERO_DW) begin
                        out_q <= fall_next_d;
                        ci_q  <= ci_inc_d;
                    end else begin
                        // Fall finished with enable low: park in IDLE.
                        state_q <= ST_IDLE;
                        out_q   <= ZERO_DW;
                        dir_q   <= 1'b0;
                        ci_q    <= CI_ZERO;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    out_q   <= ZERO_DW;
                    dir_q   <= 1'b0;
                    ci_q    <= CI_ZERO;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_value     = out_q;
    assign direction     = dir_q;
    assign period_start  = ps_q;
    assign channel_index = ci_q;
    assign period_count  = pc_q;
    assign busy          = busy_q;

endmodule
